// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default tag/value widths and the broadcast message
// layout used by the arbiter, issuer and reservation stations.
package cdb_pkg;

    localparam int TAG_W   = 4;
    localparam int DATA_W  = 8;
    localparam int ROBID_W = 8;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  val;
        logic [ROBID_W-1:0] robid;
    } cdb_msg_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake and registered CDB broadcast bundle.
// The FUs drive the master side, the arbiter sits on the slave side.
interface cdb_arbiter_if #(
    parameter int FU_COUNT = 8,
    parameter int TAG_W    = cdb_pkg::TAG_W,
    parameter int DATA_W   = cdb_pkg::DATA_W
);
    import cdb_pkg::*;

    logic [FU_COUNT-1:0]                   fu_done_valid;
    logic [FU_COUNT-1:0][TAG_W-1:0]        fu_done_tag;
    logic [FU_COUNT-1:0][DATA_W-1:0]       fu_done_val;
    logic [FU_COUNT-1:0][ROBID_W-1:0]      fu_done_robid;
    logic [FU_COUNT-1:0]                   fu_done_ready;
    logic [FU_COUNT-1:0]                   fus_busy;
    logic                                  cdbtransmit;
    logic [TAG_W-1:0]                      cdbid;
    logic [DATA_W-1:0]                     cdbval;
    logic [ROBID_W-1:0]                    cdbrobid;

    modport master (
        output fu_done_valid, fu_done_tag, fu_done_val, fu_done_robid,
        input  fu_done_ready, fus_busy, cdbtransmit, cdbid, cdbval, cdbrobid
    );

    modport slave (
        input  fu_done_valid, fu_done_tag, fu_done_val, fu_done_robid,
        output fu_done_ready, fus_busy, cdbtransmit, cdbid, cdbval, cdbrobid
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin broadcast.
// Optional macro CDB_BYPASS_EN lets an empty-slot FU win and broadcast directly.
module cdb_arbiter #(
    parameter int FU_COUNT = 8,
    parameter int TAG_W    = cdb_pkg::TAG_W,
    parameter int DATA_W   = cdb_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    cdb_arbiter_if.slave   bus
);
    import cdb_pkg::*;

    localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [FU_COUNT-1:0]              slot_valid;
    logic [FU_COUNT-1:0][TAG_W-1:0]   slot_tag;
    logic [FU_COUNT-1:0][DATA_W-1:0]  slot_val;
    logic [FU_COUNT-1:0][ROBID_W-1:0] slot_robid;
    logic [PTR_W-1:0]                 rr_ptr;

    logic [FU_COUNT-1:0] req;
    logic [FU_COUNT-1:0] grant;
    logic [FU_COUNT-1:0] handshake;
    logic [PTR_W-1:0]    winner;
    logic                grant_any;

    logic [TAG_W-1:0]    win_tag;
    logic [DATA_W-1:0]   win_val;
    logic [ROBID_W-1:0]  win_robid;

    logic                cdb_tx_q;
    logic [TAG_W-1:0]    cdb_tag_q;
    logic [DATA_W-1:0]   cdb_val_q;
    logic [ROBID_W-1:0]  cdb_robid_q;

`ifdef CDB_BYPASS_EN
    assign req = slot_valid | bus.fu_done_valid;
`else
    assign req = slot_valid;
`endif

    rr_arbiter #(.N(FU_COUNT), .IDX_W(PTR_W)) u_rr (
        .req    (req),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner),
        .any    (grant_any)
    );

    // A slot that wins this cycle is free again, so its FU may hand over the next result.
    assign bus.fu_done_ready = (rst || flush) ? '0 : (~slot_valid | grant);
    assign bus.fus_busy      = slot_valid;
    assign handshake         = bus.fu_done_valid & bus.fu_done_ready;

    assign bus.cdbtransmit = cdb_tx_q;
    assign bus.cdbid       = cdb_tag_q;
    assign bus.cdbval      = cdb_val_q;
    assign bus.cdbrobid    = cdb_robid_q;

    always_comb begin
        win_tag   = slot_tag[winner];
        win_val   = slot_val[winner];
        win_robid = slot_robid[winner];
`ifdef CDB_BYPASS_EN
        if (!slot_valid[winner]) begin
            win_tag   = bus.fu_done_tag[winner];
            win_val   = bus.fu_done_val[winner];
            win_robid = bus.fu_done_robid[winner];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid  <= '0;
            rr_ptr      <= '0;
            cdb_tx_q    <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_val_q   <= '0;
            cdb_robid_q <= '0;
        end else if (flush) begin
            slot_valid <= '0;
            cdb_tx_q   <= 1'b0;
        end else begin
            cdb_tx_q <= grant_any;
            if (grant_any) begin
                cdb_tag_q   <= win_tag;
                cdb_val_q   <= win_val;
                cdb_robid_q <= win_robid;
                rr_ptr      <= PTR_W'(wrap_inc(int'(winner), FU_COUNT));
            end
            // A bypassed winner (granted with an empty slot) goes straight out and is not stored.
            for (int i = 0; i < FU_COUNT; i++) begin
                if (handshake[i] && !(grant[i] && !slot_valid[i])) begin
                    slot_valid[i] <= 1'b1;
                    slot_tag[i]   <= bus.fu_done_tag[i];
                    slot_val[i]   <= bus.fu_done_val[i];
                    slot_robid[i] <= bus.fu_done_robid[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural slot/round-robin model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int FU = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.FU_COUNT(FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.FU_COUNT(FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [FU-1:0] stim_valid;
    cdb_msg_t      stim_msg [FU];
    bit            stim_rst;
    bit            stim_flush;

    bit            m_valid [FU];
    cdb_msg_t      m_msg [FU];
    int            m_ptr = 0;
    bit            m_tx = 1'b0;
    cdb_msg_t      m_cdb = '0;
    logic [FU-1:0] exp_ready;
    logic [FU-1:0] exp_busy;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        stim_valid = '0;
        stim_rst   = 1'b0;
        stim_flush = 1'b0;
        for (int i = 0; i < FU; i++) stim_msg[i] = '0;
    endtask

    task automatic offer(input int fu, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] val, input logic [ROBID_W-1:0] robid);
        stim_valid[fu]     = 1'b1;
        stim_msg[fu].tag   = tag;
        stim_msg[fu].val   = val;
        stim_msg[fu].robid = robid;
    endtask

    task automatic applyStimulus();
        rst               = stim_rst;
        flush             = stim_flush;
        bus.fu_done_valid = stim_valid;
        for (int i = 0; i < FU; i++) begin
            bus.fu_done_tag[i]   = stim_msg[i].tag;
            bus.fu_done_val[i]   = stim_msg[i].val;
            bus.fu_done_robid[i] = stim_msg[i].robid;
        end
    endtask

    // Oldest-pointer-first search over every FU that has something to broadcast.
    function automatic int model_winner();
        int idx;
        for (int k = 0; k < FU; k++) begin
            idx = (m_ptr + k) % FU;
`ifdef CDB_BYPASS_EN
            if (m_valid[idx] || stim_valid[idx]) return idx;
`else
            if (m_valid[idx]) return idx;
`endif
        end
        return -1;
    endfunction

    task automatic run_cycle();
        int w;
        bit byp;
        #1;
        w = (stim_rst || stim_flush) ? -1 : model_winner();
        for (int i = 0; i < FU; i++)
            exp_ready[i] = !(stim_rst || stim_flush) && (!m_valid[i] || i == w);
        checkOutput("ready", 32'(bus.fu_done_ready), 32'(exp_ready));
        @(posedge clk);
        byp = 1'b0;
        if (stim_rst) begin
            for (int i = 0; i < FU; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
            m_tx  = 1'b0;
            m_cdb = '0;
        end else if (stim_flush) begin
            for (int i = 0; i < FU; i++) m_valid[i] = 1'b0;
            m_tx = 1'b0;
        end else begin
            if (w >= 0) begin
                byp        = !m_valid[w];
                m_cdb      = byp ? stim_msg[w] : m_msg[w];
                m_tx       = 1'b1;
                m_valid[w] = 1'b0;
                m_ptr      = (w + 1) % FU;
            end else begin
                m_tx = 1'b0;
            end
            for (int i = 0; i < FU; i++) begin
                if (stim_valid[i] && exp_ready[i] && !(i == w && byp)) begin
                    m_valid[i] = 1'b1;
                    m_msg[i]   = stim_msg[i];
                end
            end
        end
        for (int i = 0; i < FU; i++) exp_busy[i] = m_valid[i];
        @(negedge clk);
        checkOutput("busy",     32'(bus.fus_busy),    32'(exp_busy));
        checkOutput("cdbtx",    32'(bus.cdbtransmit), 32'(m_tx));
        checkOutput("cdbid",    32'(bus.cdbid),       32'(m_cdb.tag));
        checkOutput("cdbval",   32'(bus.cdbval),      32'(m_cdb.val));
        checkOutput("cdbrobid", 32'(bus.cdbrobid),    32'(m_cdb.robid));
    endtask

    task automatic idle_cycle();
        clear_stim();
        applyStimulus();
        run_cycle();
    endtask

    task automatic reset_cycle();
        clear_stim();
        stim_rst = 1'b1;
        applyStimulus();
        run_cycle();
    endtask

    initial begin
        clear_stim();
        stim_rst = 1'b1;
        applyStimulus();
        run_cycle();
        reset_cycle();
        checkOutput("rst_tx",    32'(bus.cdbtransmit), 32'd0);
        checkOutput("rst_id",    32'(bus.cdbid),       32'd0);
        checkOutput("rst_busy",  32'(bus.fus_busy),    32'd0);
        checkOutput("rst_ready", 32'(bus.fu_done_ready), 32'd0);

        $display("[TB] single FU2 result");
        clear_stim(); offer(2, 4'h5, 8'h3C, 8'h07); applyStimulus(); run_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("fu2_busy1", 32'(bus.fus_busy),    32'h04);
        checkOutput("fu2_tx1",   32'(bus.cdbtransmit), 32'd0);
        idle_cycle();
        checkOutput("fu2_tx2",   32'(bus.cdbtransmit), 32'd1);
        checkOutput("fu2_id",    32'(bus.cdbid),       32'h5);
        checkOutput("fu2_val",   32'(bus.cdbval),      32'h3C);
        checkOutput("fu2_robid", 32'(bus.cdbrobid),    32'h07);
        checkOutput("fu2_busy2", 32'(bus.fus_busy),    32'h00);
`endif
        idle_cycle();
        idle_cycle();

        $display("[TB] FU0/1/3 round-robin order");
        reset_cycle();
        clear_stim(); offer(0, 4'h1, 8'h10, 8'h01); offer(1, 4'h2, 8'h20, 8'h02);
        offer(3, 4'h3, 8'h30, 8'h03); applyStimulus(); run_cycle();
        idle_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("rr_first", 32'(bus.cdbid), 32'h1);
`endif
        idle_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("rr_second", 32'(bus.cdbid), 32'h2);
`endif
        idle_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("rr_third", 32'(bus.cdbid), 32'h3);
`endif
        clear_stim(); offer(2, 4'hC, 8'hC2, 8'h22); offer(5, 4'hD, 8'hD5, 8'h55);
        applyStimulus(); run_cycle();
        idle_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("rr_ptr4", 32'(bus.cdbid), 32'hD);
`endif
        idle_cycle();
        idle_cycle();

        $display("[TB] FU7 then FU0 wrap");
        reset_cycle();
        clear_stim(); offer(6, 4'h6, 8'h66, 8'h06); applyStimulus(); run_cycle();
        idle_cycle();
        clear_stim(); offer(7, 4'h7, 8'h77, 8'h07); offer(0, 4'hA, 8'hA0, 8'h0A);
        applyStimulus(); run_cycle();
        idle_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("wrap_first", 32'(bus.cdbid), 32'h7);
`endif
        idle_cycle();
`ifndef CDB_BYPASS_EN
        checkOutput("wrap_second", 32'(bus.cdbid), 32'hA);
`endif
        idle_cycle();

        $display("[TB] FU4 streaming");
        for (int c = 0; c < 12; c++) begin
            clear_stim(); offer(4, 4'(c), 8'(c * 7), 8'(c + 100)); applyStimulus();
            #1;
            checkOutput("stream_ready4", 32'(bus.fu_done_ready[4]), 32'd1);
            run_cycle();
            if (c > 0) checkOutput("stream_tx", 32'(bus.cdbtransmit), 32'd1);
        end
        idle_cycle();
        idle_cycle();

        $display("[TB] flush with FU1 and FU6 pending");
        clear_stim(); offer(1, 4'h1, 8'h11, 8'h11); offer(6, 4'h6, 8'h66, 8'h66);
        applyStimulus(); run_cycle();
        clear_stim(); stim_flush = 1'b1; offer(3, 4'h3, 8'h33, 8'h33); applyStimulus(); run_cycle();
        checkOutput("flush_tx",   32'(bus.cdbtransmit), 32'd0);
        checkOutput("flush_busy", 32'(bus.fus_busy),    32'd0);
        idle_cycle();
        checkOutput("flush_after_tx", 32'(bus.cdbtransmit), 32'd0);

`ifdef CDB_BYPASS_EN
        $display("[TB] bypass FU3");
        reset_cycle();
        clear_stim(); offer(3, 4'h9, 8'h99, 8'h09); applyStimulus(); run_cycle();
        checkOutput("byp_tx", 32'(bus.cdbtransmit), 32'd1);
        checkOutput("byp_id", 32'(bus.cdbid),       32'h9);
`endif

        $display("[TB] reset mid-stream");
        for (int c = 0; c < 4; c++) begin
            clear_stim(); offer(4, 4'(c + 3), 8'(c + 40), 8'(c)); offer(5, 4'hE, 8'hE5, 8'h5E);
            applyStimulus(); run_cycle();
        end
        clear_stim(); stim_rst = 1'b1; offer(4, 4'hF, 8'hFF, 8'hFF); applyStimulus(); run_cycle();
        checkOutput("midrst_tx",    32'(bus.cdbtransmit), 32'd0);
        checkOutput("midrst_id",    32'(bus.cdbid),       32'd0);
        checkOutput("midrst_val",   32'(bus.cdbval),      32'd0);
        checkOutput("midrst_robid", 32'(bus.cdbrobid),    32'd0);
        checkOutput("midrst_busy",  32'(bus.fus_busy),    32'd0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            clear_stim();
            for (int i = 0; i < FU; i++)
                if ($urandom_range(99) < 40)
                    offer(i, TAG_W'($urandom), DATA_W'($urandom), ROBID_W'($urandom));
            stim_flush = ($urandom_range(24) == 0);
            stim_rst   = ($urandom_range(59) == 0);
            applyStimulus();
            run_cycle();
        end
        for (int c = 0; c < FU + 2; c++) idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FU_COUNT, default 8, number of functional units sharing the common data bus.
REQ-002 SHALL have parameter TAG_W, default 4, physical-register tag width.
REQ-003 SHALL have parameter DATA_W, default 8, result value width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all pending results.
REQ-007 SHALL have port fu_done_valid, input, FU_COUNT, per-FU result offered.
REQ-008 SHALL have port fu_done_tag, input, FU_COUNT x TAG_W, destination tag per FU.
REQ-009 SHALL have port fu_done_val, input, FU_COUNT x DATA_W, result value per FU.
REQ-010 SHALL have port fu_done_robid, input, FU_COUNT x 8, ROB id per FU.
REQ-011 SHALL have port fu_done_ready, output, FU_COUNT, per-FU result accepted this cycle.
REQ-012 SHALL have port fus_busy, output, FU_COUNT, FU holds an unbroadcast result; feeds the issuer.
REQ-013 SHALL have ports cdbtransmit (1), cdbid (TAG_W), cdbval (DATA_W), cdbrobid (8), outputs, registered CDB broadcast.

Function
REQ-014 SHALL keep one holding slot per FU (valid, tag, val, robid); handshake = fu_done_valid[i] & fu_done_ready[i].
REQ-015 SHALL drive fu_done_ready[i] = !slot_valid[i] | grant[i] (combinational; slot freed same cycle it wins).
REQ-016 SHALL drive fus_busy[i] = slot_valid[i].
REQ-017 SHALL each cycle round-robin grant at most one valid slot, searching from rr_ptr upward with wrap FU_COUNT-1 -> 0.
REQ-018 SHALL on grant of FU w register slot w contents into cdbid/cdbval/cdbrobid, set cdbtransmit=1 next cycle, clear slot w, set rr_ptr = (w+1) mod FU_COUNT.
REQ-019 SHALL with no grant set cdbtransmit=0 next cycle and hold cdbid/cdbval/cdbrobid; rr_ptr unchanged.
REQ-020 SHALL base latency: handshake in cycle N -> slot valid N+1 -> earliest cdbtransmit=1 in cycle N+2.
REQ-021 SHALL when slot granted and a new handshake occurs in the same cycle, load the new result into the slot (back-to-back, no bubble).
REQ-022 SHALL sustain one broadcast per cycle while any slot is valid; no FU waits more than FU_COUNT grants.
REQ-023 SHALL on flush clear all slots, deassert cdbtransmit next cycle, drop handshakes of that cycle, keep rr_ptr; fu_done_ready forced 0 during flush.

Reset
REQ-024 SHALL on rst clear all slots, rr_ptr=0, cdbtransmit=0, cdbid=0, cdbval=0, cdbrobid=0; rst has priority over flush and handshakes; fu_done_ready=0 while rst high.

Configuration
REQ-025 SHALL support macro CDB_BYPASS_EN: when defined, an FU with empty slot and fu_done_valid=1 also requests arbitration; if granted its input goes directly to the CDB registers (cdbtransmit in N+1) and is not stored.
REQ-026 SHALL without CDB_BYPASS_EN arbitrate only over slot_valid, giving REQ-020 latency exactly.

Structure
REQ-027 SHALL take DATA_W, TAG_W defaults and a packed cdb_msg_t (tag, val, robid) from shared package cdb_pkg, also used by the issuer and reservation stations.
REQ-028 SHALL place round-robin selection in sub-module rr_arbiter (request vector, pointer in; one-hot grant, winner index out).

Verification
REQ-029 SHALL cover: FU2 offers tag 5 val 0x3C robid 7 alone -> cdbtransmit=1, cdbid=5, cdbval=0x3C, cdbrobid=7 two cycles later; fus_busy[2]=1 for one cycle.
REQ-030 SHALL cover: FU0,1,3 valid same cycle, rr_ptr=0 -> broadcasts in order 0,1,3 on consecutive cycles; rr_ptr ends at 4.
REQ-031 SHALL cover: rr_ptr=7, FU7 and FU0 valid -> FU7 first, then FU0 (wrap).
REQ-032 SHALL cover: FU4 streams results every cycle with others idle -> cdbtransmit stays 1, ready[4] stays 1, no lost result.
REQ-033 SHALL cover: flush with FU1,FU6 slots valid -> both dropped, cdbtransmit=0 next cycle, fus_busy=0.
REQ-034 SHALL cover: CDB_BYPASS_EN defined, FU3 offers tag 9 on empty arbiter -> cdbtransmit=1, cdbid=9 in the next cycle; rst mid-stream -> all outputs 0 next cycle.
